// File: rtl/room_temp_model.sv
// Thermal plant for the air-conditioning loop: the room temperature moves one
// degree per prescaler tick, up under heat, down under cool, else towards ambient.
module room_temp_model #(
  parameter int INIT_TEMP   = 20,
  parameter int AMBIENT     = 15,
  parameter int STEP_PERIOD = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       heating,
  input  logic       cooling,
  output logic [4:0] temp,
  output logic       update,
  output logic [1:0] mode,
  output logic       fault
);

  typedef enum logic [1:0] {
    DRIFT    = 2'b00,
    HEAT     = 2'b01,
    COOL     = 2'b10,
    CONFLICT = 2'b11
  } mode_t;

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_PERIOD - 1);
  localparam logic [4:0]       INIT_T = 5'(INIT_TEMP);
  localparam logic [4:0]       AMB_T  = 5'(AMBIENT);

  mode_t            state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             tick;
  logic [4:0]       temp_d;
  logic             fault_d;
  logic [5:0]       temp_up, temp_dn;

  assign tick = (cnt_q == LAST);
  assign mode = state_q;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values and the update order inside the block is moot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DRIFT;
      cnt_q   <= '0;
      temp    <= INIT_T;
      fault   <= 1'b0;
      update  <= 1'b0;
    end else begin
      cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
      state_q <= state_d;
      temp    <= temp_d;
      fault   <= fault_d;
      update  <= tick;
    end
  end

  // NOTE: defaulting every combinational output first keeps each path fully
  // assigned, so no latch is inferred for the non-tick cycles.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case ({heating, cooling})
        2'b10:   state_d = HEAT;
        2'b01:   state_d = COOL;
        2'b11:   state_d = CONFLICT;
        default: state_d = DRIFT;
      endcase
    end
  end

  // One-degree steps on a 6-bit path so saturation is detected, never wrapped.
  always_comb begin
    temp_up = {1'b0, temp} + 6'd1;
    temp_dn = {1'b0, temp} - 6'd1;
    temp_d  = temp;
    fault_d = fault;
    if (tick) begin
      unique case (state_d)
        HEAT:     temp_d = temp_up[5] ? 5'd31 : temp_up[4:0];
        COOL:     temp_d = temp_dn[5] ? 5'd0  : temp_dn[4:0];
        CONFLICT: fault_d = 1'b1;
        default: begin
          if (temp > AMB_T)      temp_d = temp_dn[4:0];
          else if (temp < AMB_T) temp_d = temp_up[4:0];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_room_temp_model.sv
// Scoreboard bench for room_temp_model: the driver runs an abstract thermal
// model and queues the expected result of every tick; the monitor checks updates.
module tb_room_temp_model;

  localparam int INIT_TEMP   = 20;
  localparam int AMBIENT     = 15;
  localparam int STEP_PERIOD = 4;
  localparam int CNT_W       = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       heating = 1'b0;
  logic       cooling = 1'b0;
  logic [4:0] temp;
  logic       update;
  logic [1:0] mode;
  logic       fault;

  room_temp_model #(
    .INIT_TEMP  (INIT_TEMP),
    .AMBIENT    (AMBIENT),
    .STEP_PERIOD(STEP_PERIOD),
    .CNT_W      (CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .heating(heating),
    .cooling(cooling),
    .temp   (temp),
    .update (update),
    .mode   (mode),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int temp;
    int mode;
    int fault;
    int edge_n;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state: temperature, sticky fault, edges since reset.
  int m_temp  = INIT_TEMP;
  int m_fault = 0;
  int m_n     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model for the coming edge.
  task automatic drive(input bit h, input bit c, input bit r);
    exp_t e;
    @(negedge clk);
    heating = h;
    cooling = c;
    rst     = r;
    if (r) begin
      m_temp  = INIT_TEMP;
      m_fault = 0;
      m_n     = 0;
    end else begin
      m_n++;
      if (m_n % STEP_PERIOD == 0) begin
        if (h && !c) begin
          e.mode = 1;
          m_temp = (m_temp + 1 > 31) ? 31 : m_temp + 1;
        end else if (c && !h) begin
          e.mode = 2;
          m_temp = (m_temp - 1 < 0) ? 0 : m_temp - 1;
        end else if (h && c) begin
          e.mode  = 3;
          m_fault = 1;
        end else begin
          e.mode = 0;
          if (m_temp > AMBIENT)      m_temp = m_temp - 1;
          else if (m_temp < AMBIENT) m_temp = m_temp + 1;
        end
        e.temp   = m_temp;
        e.fault  = m_fault;
        e.edge_n = m_n;
        sb.push_back(e);
      end
    end
  endtask

  function automatic bit next_is_tick();
    return ((m_n + 1) % STEP_PERIOD) == 0;
  endfunction

  // Monitor: sample #1 after each rising edge.
  initial begin
    int   mon_n = 0;
    logic r_s;
    exp_t e;
    forever begin
      @(posedge clk);
      r_s = rst;
      #1;
      if (r_s === 1'b1) begin
        if (sb.size() != 0) begin
          check("lost_update", sb.size(), 0);
          sb.delete();
        end
        mon_n = 0;
        check("rst_temp", temp, INIT_TEMP);
        check("rst_mode", mode, 0);
        check("rst_fault", fault, 0);
        check("rst_update", update, 0);
      end else begin
        mon_n++;
        if (update === 1'b1) begin
          if (sb.size() == 0) begin
            check("spurious_update", 1, 0);
          end else begin
            e = sb.pop_front();
            check("update_edge", mon_n, e.edge_n);
            check("temp", temp, e.temp);
            check("mode", mode, e.mode);
            check("fault", fault, e.fault);
          end
        end else if (update !== 1'b0) begin
          check("update_known", update, 0);
        end
      end
    end
  end

  initial begin
    repeat (2) drive(0, 0, 1);
    // Drift from INIT down to ambient, then hold.
    repeat (8 * STEP_PERIOD) drive(0, 0, 0);

    // Heat to saturation.
    drive(0, 0, 1);
    repeat (14 * STEP_PERIOD) drive(1, 0, 0);

    // Cool to saturation.
    drive(0, 0, 1);
    repeat (24 * STEP_PERIOD) drive(0, 1, 0);

    // Conflict for one tick, then heat with fault kept.
    drive(0, 0, 1);
    repeat (STEP_PERIOD) drive(1, 1, 0);
    repeat (STEP_PERIOD) drive(1, 0, 0);

    // Heating toggles between ticks but is low on every tick edge.
    repeat (10 * STEP_PERIOD) begin
      if (next_is_tick()) drive(0, 0, 0);
      else                drive(1'($urandom_range(0, 1)), 0, 0);
    end

    // Climb to 27 with fault set, then reset mid-period.
    repeat (12 * STEP_PERIOD) drive(1, 0, 0);
    drive(1, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    repeat (3 * STEP_PERIOD) drive(0, 0, 0);

    // Random traffic with occasional resets.
    repeat (800) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 149) == 0));
    end

    repeat (2 * STEP_PERIOD) drive(0, 0, 0);
    @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
